// File: rtl/sram_bank_arbiter.sv
// Banked single-port SRAM controller. Two requesters (CPU and Wishbone loader)
// share N_BANKS macros through a round-robin arbiter and a four-state FSM:
// IDLE grants, ISSUE drives one macro for one cycle, WAIT covers the macro
// read latency, DONE pulses the granted ack (and err for out-of-range banks).
module sram_bank_arbiter #(
    parameter int unsigned N_BANKS = 4,
    parameter int unsigned BANK_AW = 10,
    parameter int unsigned DW      = 16,
    parameter int unsigned LANE_W  = 8,
    parameter int unsigned RD_LAT  = 1,
    localparam int unsigned NL     = DW / LANE_W,
    localparam int unsigned BW     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    localparam int unsigned AW     = BANK_AW + BW
) (
    input  logic                   clk,
    input  logic                   rst,
    // CPU port
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    input  logic [NL-1:0]          cpu_be,
    output logic                   cpu_ack,
    output logic [DW-1:0]          cpu_rdata,
    // Wishbone-side loader port
    input  logic                   wb_req,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_addr,
    input  logic [DW-1:0]          wb_wdata,
    input  logic [NL-1:0]          wb_be,
    output logic                   wb_ack,
    output logic [DW-1:0]          wb_rdata,
    // SRAM macro pins
    output logic [N_BANKS-1:0]     mem_csb,
    output logic                   mem_web,
    output logic [NL-1:0]          mem_wmask,
    output logic [BANK_AW-1:0]     mem_addr,
    output logic [DW-1:0]          mem_din,
    input  logic [N_BANKS*DW-1:0]  mem_dout,
    // Status
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned CntW = 3;
    localparam logic PortCpu = 1'b0;
    localparam logic PortWb  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic               last_grant_q;
    logic               cmd_port_q;
    logic               cmd_we_q;
    logic               cmd_oor_q;
    logic [BW-1:0]      cmd_bank_q;
    logic [BANK_AW-1:0] cmd_addr_q;
    logic [DW-1:0]      cmd_wdata_q;
    logic [NL-1:0]      cmd_be_q;
    logic [DW-1:0]      cpu_rdata_q;
    logic [DW-1:0]      wb_rdata_q;

    logic               req_any;
    logic               grant_wb;
    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [NL-1:0]      sel_be;
    logic [BW-1:0]      sel_bank;
    logic               sel_oor;
    logic [DW-1:0]      rd_word;
    logic               rd_last;

    // Arbitration: a lone requester wins; a tie goes to the port not granted last.
    always_comb begin
        req_any   = cpu_req | wb_req;
        grant_wb  = wb_req & (~cpu_req | (last_grant_q == PortCpu));
        sel_we    = grant_wb ? wb_we    : cpu_we;
        sel_addr  = grant_wb ? wb_addr  : cpu_addr;
        sel_wdata = grant_wb ? wb_wdata : cpu_wdata;
        sel_be    = grant_wb ? wb_be    : cpu_be;
        // With a single bank the bank field carries no information.
        sel_bank  = (N_BANKS == 1) ? '0 : sel_addr[AW-1:BANK_AW];
        sel_oor   = (N_BANKS > 1) && (32'(sel_bank) >= N_BANKS);
    end

    // Read data mux from the flattened macro outputs.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_BANKS; k++) begin
            if (cmd_bank_q == BW'(k)) begin
                rd_word = mem_dout[k*DW +: DW];
            end
        end
    end

    // FSM next state and read-latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_last = (cnt_q == CntW'(RD_LAT - 1));
        case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = (cmd_we_q || cmd_oor_q) ? StDone : StWait;
            end
            StWait: begin
                if (rd_last) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command register, loaded on every grant; last_grant follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PortWb;
            cmd_port_q   <= PortCpu;
            cmd_we_q     <= 1'b0;
            cmd_oor_q    <= 1'b0;
            cmd_bank_q   <= '0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_be_q     <= '0;
        end else if (state_q == StIdle && req_any) begin
            last_grant_q <= grant_wb;
            cmd_port_q   <= grant_wb;
            cmd_we_q     <= sel_we;
            cmd_oor_q    <= sel_oor;
            cmd_bank_q   <= sel_bank;
            cmd_addr_q   <= sel_addr[BANK_AW-1:0];
            cmd_wdata_q  <= sel_wdata;
            cmd_be_q     <= sel_be;
        end
    end

    // Per-port read data: loaded on the last WAIT cycle, zeroed by an
    // out-of-range read, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            wb_rdata_q  <= '0;
        end else if (state_q == StWait && rd_last) begin
            if (cmd_port_q == PortWb) begin
                wb_rdata_q <= rd_word;
            end else begin
                cpu_rdata_q <= rd_word;
            end
        end else if (state_q == StIssue && cmd_oor_q && !cmd_we_q) begin
            if (cmd_port_q == PortWb) begin
                wb_rdata_q <= '0;
            end else begin
                cpu_rdata_q <= '0;
            end
        end
    end

    // Macro pins: idle values everywhere except the ISSUE cycle of an in-range
    // access, so at most one csb is ever low and only for one cycle.
    always_comb begin
        mem_csb   = '1;
        mem_web   = 1'b1;
        mem_wmask = '0;
        mem_addr  = '0;
        mem_din   = '0;
        if (state_q == StIssue && !cmd_oor_q) begin
            mem_addr = cmd_addr_q;
            mem_din  = cmd_wdata_q;
            for (int k = 0; k < N_BANKS; k++) begin
                if (cmd_bank_q == BW'(k)) begin
                    mem_csb[k] = 1'b0;
                end
            end
            if (cmd_we_q) begin
                mem_web   = 1'b0;
                mem_wmask = cmd_be_q;
            end
        end
    end

    // Handshake and status outputs.
    always_comb begin
        cpu_ack   = (state_q == StDone) && (cmd_port_q == PortCpu);
        wb_ack    = (state_q == StDone) && (cmd_port_q == PortWb);
        err       = (state_q == StDone) && cmd_oor_q;
        busy      = (state_q != StIdle);
        cpu_rdata = cpu_rdata_q;
        wb_rdata  = wb_rdata_q;
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter. Three instances share the request
// fields: A (4 banks, RD_LAT=1) and B (4 banks, RD_LAT=3) sit on a behavioural
// lane-masked SRAM model; C (3 banks) reads a constant pattern and exercises
// out-of-range detection. 'sel' routes the req lines and observed outputs.
module tb_sram_bank_arbiter;

    localparam int AW = 12;
    localparam int LAT [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst;
    int   sel;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, wb_req, wb_we;
    logic [11:0] cpu_addr, wb_addr;
    logic [15:0] cpu_wdata, wb_wdata;
    logic [1:0]  cpu_be, wb_be;

    logic        cpu_ack_v [3];
    logic        wb_ack_v  [3];
    logic [15:0] cpu_rd_v  [3];
    logic [15:0] wb_rd_v   [3];
    logic [3:0]  csb_v     [3];
    logic        web_v     [3];
    logic [1:0]  wmask_v   [3];
    logic [9:0]  maddr_v   [3];
    logic [15:0] din_v     [3];
    logic        busy_v    [3];
    logic        err_v     [3];
    logic [2:0]  csb_c;
    logic [63:0] dout_v    [2];

    assign csb_v[2] = {1'b1, csb_c};

    sram_bank_arbiter #(.N_BANKS(4), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req && sel == 0), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack_v[0]),
        .cpu_rdata(cpu_rd_v[0]),
        .wb_req(wb_req && sel == 0), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_wdata(wb_wdata), .wb_be(wb_be), .wb_ack(wb_ack_v[0]), .wb_rdata(wb_rd_v[0]),
        .mem_csb(csb_v[0]), .mem_web(web_v[0]), .mem_wmask(wmask_v[0]),
        .mem_addr(maddr_v[0]), .mem_din(din_v[0]), .mem_dout(dout_v[0]),
        .busy(busy_v[0]), .err(err_v[0])
    );

    sram_bank_arbiter #(.N_BANKS(4), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req && sel == 1), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack_v[1]),
        .cpu_rdata(cpu_rd_v[1]),
        .wb_req(wb_req && sel == 1), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_wdata(wb_wdata), .wb_be(wb_be), .wb_ack(wb_ack_v[1]), .wb_rdata(wb_rd_v[1]),
        .mem_csb(csb_v[1]), .mem_web(web_v[1]), .mem_wmask(wmask_v[1]),
        .mem_addr(maddr_v[1]), .mem_din(din_v[1]), .mem_dout(dout_v[1]),
        .busy(busy_v[1]), .err(err_v[1])
    );

    sram_bank_arbiter #(.N_BANKS(3), .RD_LAT(1)) u_dut_c (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req && sel == 2), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack_v[2]),
        .cpu_rdata(cpu_rd_v[2]),
        .wb_req(wb_req && sel == 2), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_wdata(wb_wdata), .wb_be(wb_be), .wb_ack(wb_ack_v[2]), .wb_rdata(wb_rd_v[2]),
        .mem_csb(csb_c), .mem_web(web_v[2]), .mem_wmask(wmask_v[2]),
        .mem_addr(maddr_v[2]), .mem_din(din_v[2]), .mem_dout(48'hA5A5_A5A5_A5A5),
        .busy(busy_v[2]), .err(err_v[2])
    );

    // Behavioural SRAM for A and B: lane-masked writes, reads delayed by LAT
    // clocks; a bank not being read drives 16'hDEAD.
    logic [15:0] mem   [2][4][1024];
    logic        pval  [2][3];
    logic [1:0]  pbank [2][3];
    logic [15:0] pdata [2][3];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int s = 2; s > 0; s--) begin
                pval[d][s]  <= pval[d][s-1];
                pbank[d][s] <= pbank[d][s-1];
                pdata[d][s] <= pdata[d][s-1];
            end
            pval[d][0] <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!csb_v[d][k]) begin
                    if (!web_v[d]) begin
                        for (int l = 0; l < 2; l++) begin
                            if (wmask_v[d][l]) begin
                                mem[d][k][maddr_v[d]][l*8 +: 8] <= din_v[d][l*8 +: 8];
                            end
                        end
                    end else begin
                        pval[d][0]  <= 1'b1;
                        pbank[d][0] <= k[1:0];
                        pdata[d][0] <= mem[d][k][maddr_v[d]];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            dout_v[d] = '0;
            for (int k = 0; k < 4; k++) begin
                dout_v[d][k*16 +: 16] =
                    (pval[d][LAT[d]-1] && pbank[d][LAT[d]-1] == k[1:0]) ?
                    pdata[d][LAT[d]-1] : 16'hDEAD;
            end
        end
    end

    logic        obs_cpu_ack, obs_wb_ack, obs_web, obs_busy, obs_err;
    logic [15:0] obs_cpu_rd, obs_wb_rd, obs_din;
    logic [3:0]  obs_csb;
    logic [1:0]  obs_wmask;
    logic [9:0]  obs_addr;

    always_comb begin
        obs_cpu_ack = cpu_ack_v[sel];
        obs_wb_ack  = wb_ack_v[sel];
        obs_cpu_rd  = cpu_rd_v[sel];
        obs_wb_rd   = wb_rd_v[sel];
        obs_csb     = csb_v[sel];
        obs_web     = web_v[sel];
        obs_wmask   = wmask_v[sel];
        obs_addr    = maddr_v[sel];
        obs_din     = din_v[sel];
        obs_busy    = busy_v[sel];
        obs_err     = err_v[sel];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last transaction; latencies are -1 when never seen.
    int          lat_c, lat_w, lat_err, n_low;
    logic        multi_low;
    logic [3:0]  s_csb;
    logic        s_web;
    logic [1:0]  s_wmask;
    logic [9:0]  s_addr;
    logic [15:0] s_din;

    task automatic cpu_set(input logic we, input logic [11:0] a, input logic [15:0] d,
                           input logic [1:0] be);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    endtask

    task automatic wb_set(input logic we, input logic [11:0] a, input logic [15:0] d,
                          input logic [1:0] be);
        wb_we = we; wb_addr = a; wb_wdata = d; wb_be = be;
    endtask

    // Raise the chosen reqs; cycle 0 is the cycle in which they rise. Each req
    // is dropped in its ack cycle. Snapshot the first macro access.
    task automatic txn(input bit c, input bit w);
        bit c_pend, w_pend;
        lat_c = -1; lat_w = -1; lat_err = -1; n_low = 0; multi_low = 1'b0;
        @(negedge clk);
        cpu_req = c; wb_req = w; c_pend = c; w_pend = w;
        for (int n = 1; n <= 20 && (c_pend || w_pend); n++) begin
            @(negedge clk);
            if (obs_csb != 4'hF) begin
                if (n_low == 0) begin
                    s_csb = obs_csb; s_web = obs_web; s_wmask = obs_wmask;
                    s_addr = obs_addr; s_din = obs_din;
                end
                n_low++;
                if ($countones(~obs_csb) > 1) multi_low = 1'b1;
            end
            if (obs_err) lat_err = n;
            if (obs_cpu_ack) begin lat_c = n; cpu_req = 1'b0; c_pend = 1'b0; end
            if (obs_wb_ack)  begin lat_w = n; wb_req = 1'b0;  w_pend = 1'b0; end
        end
        cpu_req = 1'b0; wb_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; rst = 1'b1; cpu_req = 1'b0; wb_req = 1'b0;
        cpu_set(0, '0, '0, '0);
        wb_set(0, '0, '0, '0);
        repeat (2) @(negedge clk);
        check_eq("rst_pins", {obs_csb, obs_web, obs_wmask, obs_addr, obs_din},
                 {4'hF, 1'b1, 2'b00, 10'h000, 16'h0000});
        check_eq("rst_status", {obs_cpu_ack, obs_wb_ack, obs_err, obs_busy}, 4'b0000);
        check_eq("rst_rdata", {obs_cpu_rd, obs_wb_rd}, 32'h0);
        rst = 1'b0;

        // A: full-word write to bank 1
        cpu_set(1, 12'h405, 16'hBEEF, 2'b11);
        txn(1, 0);
        check_eq("wr_lat", lat_c, 2);
        check_eq("wr_csb", s_csb, 4'b1101);
        check_eq("wr_addr", s_addr, 10'h005);
        check_eq("wr_web_mask", {s_web, s_wmask}, 3'b011);
        check_eq("wr_din", s_din, 16'hBEEF);
        check_eq("wr_one_issue", n_low, 1);

        // A: read back
        cpu_set(0, 12'h405, 16'h0000, 2'b00);
        txn(1, 0);
        check_eq("rd_lat1", lat_c, 3);
        check_eq("rd_data1", obs_cpu_rd, 16'hBEEF);
        check_eq("rd_pins", {s_csb, s_web, s_wmask}, {4'b1101, 1'b1, 2'b00});

        // A: tie after CPU grants -> WB first
        cpu_set(1, 12'h810, 16'h1111, 2'b11);
        wb_set(1, 12'hC20, 16'h2222, 2'b11);
        txn(1, 1);
        check_eq("tie1_wb_lat", lat_w, 2);
        check_eq("tie1_cpu_lat", lat_c, 5);
        check_eq("tie1_first_bank", s_csb, 4'b0111);
        check_eq("tie1_issues", {multi_low, 8'(n_low)}, {1'b0, 8'd2});

        // A: lone WB write, then tie -> CPU first
        wb_set(1, 12'h021, 16'h3333, 2'b11);
        txn(0, 1);
        check_eq("wb_only_lat", lat_w, 2);
        check_eq("wb_only_csb", s_csb, 4'b1110);
        cpu_set(1, 12'h811, 16'h4444, 2'b11);
        wb_set(1, 12'hC21, 16'h5555, 2'b11);
        txn(1, 1);
        check_eq("tie2_cpu_lat", lat_c, 2);
        check_eq("tie2_wb_lat", lat_w, 5);
        check_eq("tie2_first_bank", s_csb, 4'b1011);

        // A: upper-lane write, then be=0 write, then read back
        cpu_set(1, 12'h405, 16'h12AB, 2'b10);
        txn(1, 0);
        check_eq("lane_mask_din", {s_wmask, s_din}, {2'b10, 16'h12AB});
        cpu_set(1, 12'h405, 16'hFFFF, 2'b00);
        txn(1, 0);
        check_eq("be0_lat_mask", {8'(lat_c), s_wmask}, {8'd2, 2'b00});
        cpu_set(0, 12'h405, 16'h0000, 2'b00);
        txn(1, 0);
        check_eq("lane_rd", obs_cpu_rd, 16'h12EF);
        check_eq("lane_rd_wb_untouched", obs_wb_rd, 16'h0000);

        // A: WB read of the tie write; CPU rdata must hold
        wb_set(0, 12'hC20, 16'h0000, 2'b00);
        txn(0, 1);
        check_eq("wb_rd", {8'(lat_w), obs_wb_rd}, {8'd3, 16'h2222});
        check_eq("wb_rd_cpu_held", obs_cpu_rd, 16'h12EF);
        check_eq("a_no_err", lat_err, -1);

        // B: RD_LAT=3
        sel = 1;
        cpu_set(1, 12'h405, 16'hBEEF, 2'b11);
        txn(1, 0);
        cpu_set(0, 12'h405, 16'h0000, 2'b00);
        txn(1, 0);
        check_eq("rd_lat3", lat_c, 5);
        check_eq("rd_data3", obs_cpu_rd, 16'hBEEF);

        // B: reset in the middle of WAIT
        @(negedge clk);
        cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("wait_busy", obs_busy, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_pins", {obs_csb, obs_busy, obs_cpu_ack}, {4'hF, 1'b0, 1'b0});
        check_eq("midrst_rdata", obs_cpu_rd, 16'h0000);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cpu_set(1, 12'h406, 16'hAAAA, 2'b11);
        txn(1, 0);
        check_eq("postrst_wr", {8'(lat_c), s_csb, s_addr}, {8'd2, 4'b1101, 10'h006});
        cpu_set(0, 12'h406, 16'h0000, 2'b00);
        txn(1, 0);
        check_eq("postrst_rd", {8'(lat_c), obs_cpu_rd}, {8'd5, 16'hAAAA});

        // C: three banks, in-range read then out-of-range read and write
        sel = 2;
        wb_set(0, 12'h005, 16'h0000, 2'b00);
        txn(0, 1);
        check_eq("c_rd_ok", {8'(lat_w), obs_wb_rd, s_csb}, {8'd3, 16'hA5A5, 4'b1110});
        check_eq("c_rd_ok_err", lat_err, -1);
        wb_set(0, 12'hC00, 16'h0000, 2'b00);
        txn(0, 1);
        check_eq("oor_rd_lat_err", {8'(lat_w), 8'(lat_err)}, {8'd2, 8'd2});
        check_eq("oor_rd_no_csb", n_low, 0);
        check_eq("oor_rd_data", obs_wb_rd, 16'h0000);
        cpu_set(1, 12'hC33, 16'h7777, 2'b11);
        txn(1, 0);
        check_eq("oor_wr", {8'(lat_c), 8'(lat_err), 8'(n_low)}, {8'd2, 8'd2, 8'd0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
